clock_divider: RTL and testbench

- Divides one fast input clock by an integer factor N.
- Output is 50% duty for both even and odd N; odd N uses a falling-edge half-period correction.
- Several instances share one dedicated clock-divider reset, so all divided clocks are phase-aligned. Their first rising edges coincide, and they coincide again every LCM of the factors.
- Used to generate per-domain clocks for multi-clock-domain fabric experiments.

---
 rtl/clock_divider.sv | 90 +++++++++
 tb/tb_clock_divider.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/clock_divider.sv
// clock_divider
//   Divides the fast source clock by the integer factor p_divideby (N) and
//   produces a 50% duty-cycle output for both even and odd N. Instances that
//   share the same clk_reset are phase-aligned: every instance starts its
//   count at 0 on the same clk rising edge.
//
// Parameters:
//   p_divideby        division factor N (N >= 1; N < 1 is an elaboration error)
//
// Ports:
//   clk               fast source clock (both edges are used for odd N)
//   clk_reset         asynchronous active-low reset; holds the output low
//   clk_divided       divided clock, period N x clk period
//   clk_divided_rise  one-clk-cycle pulse starting at each rising edge of
//                     clk_divided (present only with CLOCK_DIVIDER_RISE_PULSE_EN)
//
// Optional feature macro: CLOCK_DIVIDER_RISE_PULSE_EN
module clock_divider #(
  parameter int p_divideby = 2
) (
  input  logic clk,
  input  logic clk_reset,
  output logic clk_divided
`ifdef CLOCK_DIVIDER_RISE_PULSE_EN
  ,
  output logic clk_divided_rise
`endif
);

  localparam int c_cnt_w = (p_divideby > 1) ? $clog2(p_divideby) : 1;

  if (p_divideby < 1) begin : g_bad
    $error("clock_divider: p_divideby must be >= 1 (got %0d)", p_divideby);
    assign clk_divided = 1'b0;
`ifdef CLOCK_DIVIDER_RISE_PULSE_EN
    assign clk_divided_rise = 1'b0;
`endif
  end else if (p_divideby == 1) begin : g_pass
    // Divide-by-one is a gated pass-through of the source clock.
    assign clk_divided = clk & clk_reset;
`ifdef CLOCK_DIVIDER_RISE_PULSE_EN
    always_ff @(posedge clk or negedge clk_reset) begin
      if (!clk_reset) clk_divided_rise <= 1'b0;
      else            clk_divided_rise <= 1'b1;
    end
`endif
  end else begin : g_div
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(p_divideby - 1);
    // N/2 truncates, so for odd N this is (N-1)/2 posedge-cycles of p; the
    // negedge copy stretches the high phase by the missing half period.
    localparam logic [c_cnt_w-1:0] c_high = c_cnt_w'(p_divideby / 2);

    logic [c_cnt_w-1:0] cnt;
    logic               p;

    // cnt holds the phase index of the clk cycle that starts at the next
    // rising edge; p is set from that index, so the first edge after reset
    // release (cnt == 0) raises the output.
    always_ff @(posedge clk or negedge clk_reset) begin
      if (!clk_reset) begin
        cnt <= '0;
        p   <= 1'b0;
      end else begin
        cnt <= (cnt == c_last) ? '0 : cnt + c_cnt_w'(1);
        p   <= (cnt < c_high);
      end
    end

    if ((p_divideby % 2) == 1) begin : g_odd
      logic n;

      always_ff @(negedge clk or negedge clk_reset) begin
        if (!clk_reset) n <= 1'b0;
        else            n <= p;
      end

      assign clk_divided = p | n;
    end else begin : g_even
      assign clk_divided = p;
    end

`ifdef CLOCK_DIVIDER_RISE_PULSE_EN
    always_ff @(posedge clk or negedge clk_reset) begin
      if (!clk_reset) clk_divided_rise <= 1'b0;
      else            clk_divided_rise <= (cnt == '0);
    end
`endif
  end

endmodule

// File: tb/tb_clock_divider.sv
`timescale 1ns/10ps
// tb_clock_divider
//   Self-checking bench for clock_divider. Instances with N = 1, 2, 3, 9 share
//   reset A (released at 9 ns); instances with N = 3, 9 share reset B, which
//   is pulsed mid-operation at fixed and at random times. Outputs are
//   sampled half-way between clk edges and compared against a model that
//   describes the output as a function of time since the first active edge.
module tb_clock_divider;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic d1, d2, d3, d9, d3r, d9r;
`ifdef CLOCK_DIVIDER_RISE_PULSE_EN
  logic r1, r2, r3, r9, r3r, r9r;
`endif

  int  errors = 0;
  int  checks = 0;
  logic b_rel;
  real  t0_b;

  clock_divider #(.p_divideby(1)) u1 (.clk(clk), .clk_reset(rst_a), .clk_divided(d1)
`ifdef CLOCK_DIVIDER_RISE_PULSE_EN
    , .clk_divided_rise(r1)
`endif
  );
  clock_divider #(.p_divideby(2)) u2 (.clk(clk), .clk_reset(rst_a), .clk_divided(d2)
`ifdef CLOCK_DIVIDER_RISE_PULSE_EN
    , .clk_divided_rise(r2)
`endif
  );
  clock_divider #(.p_divideby(3)) u3 (.clk(clk), .clk_reset(rst_a), .clk_divided(d3)
`ifdef CLOCK_DIVIDER_RISE_PULSE_EN
    , .clk_divided_rise(r3)
`endif
  );
  clock_divider #(.p_divideby(9)) u9 (.clk(clk), .clk_reset(rst_a), .clk_divided(d9)
`ifdef CLOCK_DIVIDER_RISE_PULSE_EN
    , .clk_divided_rise(r9)
`endif
  );
  clock_divider #(.p_divideby(3)) u3r (.clk(clk), .clk_reset(rst_b), .clk_divided(d3r)
`ifdef CLOCK_DIVIDER_RISE_PULSE_EN
    , .clk_divided_rise(r3r)
`endif
  );
  clock_divider #(.p_divideby(9)) u9r (.clk(clk), .clk_reset(rst_b), .clk_divided(d9r)
`ifdef CLOCK_DIVIDER_RISE_PULSE_EN
    , .clk_divided_rise(r9r)
`endif
  );

  initial begin
    clk = 1'b1;
    forever #1 clk = ~clk;
  end

  // Output is high for the first N of every 2N nanoseconds (half clk
  // periods) counted from the first active rising edge t0.
  function automatic logic model_out(int n, real t0, logic rel, real t);
    int h;
    if (!rel || t < t0) return 1'b0;
    h = int'($floor(t - t0));
    return (h % (2 * n)) < n;
  endfunction

  // Rise pulse: high for the first clk period (2 ns) of every output period.
  function automatic logic model_rise(int n, real t0, logic rel, real t);
    int h;
    if (!rel || t < t0) return 1'b0;
    h = int'($floor(t - t0));
    return (h % (2 * n)) < 2;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0.2f observed=%b expected=%b", tag, $realtime, obs, exp);
    end
  endtask

  task automatic sample_all();
    real t;
    t = $realtime;
    // N = 1 follows clk, whose rising edges sit at even ns from t = 0.
    check("n1_out",  d1,  model_out(1, 0.0,  rst_a, t));
    check("n2_out",  d2,  model_out(2, 10.0, rst_a, t));
    check("n3_out",  d3,  model_out(3, 10.0, rst_a, t));
    check("n9_out",  d9,  model_out(9, 10.0, rst_a, t));
    check("n3r_out", d3r, model_out(3, t0_b, b_rel, t));
    check("n9r_out", d9r, model_out(9, t0_b, b_rel, t));
`ifdef CLOCK_DIVIDER_RISE_PULSE_EN
    check("n2_rise",  r2,  model_rise(2, 10.0, rst_a, t));
    check("n3_rise",  r3,  model_rise(3, 10.0, rst_a, t));
    check("n9_rise",  r9,  model_rise(9, 10.0, rst_a, t));
    check("n3r_rise", r3r, model_rise(3, t0_b, b_rel, t));
    check("n9r_rise", r9r, model_rise(9, t0_b, b_rel, t));
    if (t > 10.0) check("n1_rise", r1, 1'b1);
`endif
  endtask

  task automatic advance_to(input real t);
    if (t > $realtime) #(t - $realtime);
  endtask

  // Sample at every x.5 ns point strictly before t_end.
  task automatic run_until(input real t_end);
    real nxt;
    nxt = $floor($realtime - 0.5) + 1.5;
    while (nxt < t_end) begin
      advance_to(nxt);
      sample_all();
      nxt = nxt + 1.0;
    end
  endtask

  initial begin
    real ta, tr;
    rst_a = 1'b0;
    rst_b = 1'b0;
    b_rel = 1'b0;
    t0_b  = 0.0;

    // Reset state, both before and after the clock has toggled.
    #0.2;
    check("reset_n2", d2, 1'b0);
    check("reset_n9", d9, 1'b0);
    run_until(9.0);

    advance_to(9.0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    b_rel = 1'b1;
    t0_b  = 10.0;
    run_until(15.3);

    // Asynchronous reset in the middle of the N=9 high phase.
    advance_to(15.3);
    check("pre_reset_n9r", d9r, 1'b1);
    rst_b = 1'b0;
    b_rel = 1'b0;
    #0.1;
    check("async_reset_n9r", d9r, 1'b0);
    check("async_reset_n3r", d3r, 1'b0);
    run_until(21.0);

    advance_to(21.0);
    rst_b = 1'b1;
    b_rel = 1'b1;
    t0_b  = 22.0;
    run_until(60.0);

    // Randomly placed reset pulses, released mid clk-low phase.
    for (int i = 0; i < 4; i++) begin
      ta = $floor($realtime) + real'($urandom_range(5, 15)) +
           (($urandom_range(0, 1) == 0) ? 0.2 : 0.7);
      run_until(ta);
      advance_to(ta);
      rst_b = 1'b0;
      b_rel = 1'b0;
      #0.1;
      check("rand_reset_n9r", d9r, 1'b0);
      check("rand_reset_n3r", d3r, 1'b0);
      tr = 2.0 * $floor((ta + 1.0) / 2.0) + 1.3 + 2.0 * real'($urandom_range(0, 3));
      run_until(tr);
      advance_to(tr);
      rst_b = 1'b1;
      b_rel = 1'b1;
      t0_b  = tr + 0.7;
      run_until(tr + 40.0);
    end

    // Long run: over 1000 clk cycles with no phase drift between instances.
    run_until(2100.0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
